// File: rtl/instruction_memory_controller_if.sv
// Refill handshake and preload port between the instruction cache side
// (master) and the backing instruction memory controller (slave).
interface instruction_memory_controller_if #(
   parameter int LOAD_AW = 8
);
   logic               mem_read;
   logic [27:0]        mem_address;
   logic [127:0]       mem_readinst;
   logic               mem_busywait;
   logic               load_en;
   logic [LOAD_AW-1:0] load_addr;
   logic [31:0]        load_data;

   modport master (
      output mem_read, mem_address, load_en, load_addr, load_data,
      input  mem_readinst, mem_busywait
   );

   modport slave (
      input  mem_read, mem_address, load_en, load_addr, load_data,
      output mem_readinst, mem_busywait
   );
endinterface

// File: rtl/instruction_memory_controller.sv
// Backing instruction memory behind the instruction cache. A refill waits a
// fixed access latency, then reads four 32-bit words (one per cycle) into the
// lanes of a 128-bit block. Words past the end of the array read as a NOP.
// A word-wide preload port writes the array while the controller is idle.
module instruction_memory_controller #(
   parameter int          DEPTH_WORDS    = 256,
   parameter int          ACCESS_LATENCY = 4,
   parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
   input  logic                            clock,
   input  logic                            reset,
   instruction_memory_controller_if.slave  bus
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int LAT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_START =
      (ACCESS_LATENCY > 0) ? LAT_W'(ACCESS_LATENCY - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      BEAT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            state;
   logic [27:0]       blk_q;
   logic [1:0]        beat_cnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic [127:0]      readinst_q;
   logic [31:0]       word_array [DEPTH_WORDS];

   logic [29:0]       word_idx;
   logic              word_in_range;
   logic [31:0]       beat_word;
   logic              load_ok;

   // Full 30-bit word index: block number times four plus beat, no wrap.
   assign word_idx      = {blk_q, beat_cnt};
   assign word_in_range = (word_idx < 30'(DEPTH_WORDS));
   assign beat_word     = word_in_range ? word_array[word_idx[AW-1:0]] : NOP_WORD;

   // Preload only when idle and no refill is being requested (read wins).
   assign load_ok = !reset && (state == IDLE) && !bus.mem_read && bus.load_en;

   assign bus.mem_readinst = readinst_q;

   // Busywait rises in the same cycle as the request so the cache never sees
   // a stale low; it drops only for the single DONE cycle.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      bus.mem_busywait = 1'b0;
      case (state)
         IDLE:    bus.mem_busywait = bus.mem_read;
         ACCESS:  bus.mem_busywait = 1'b1;
         BEAT:    bus.mem_busywait = 1'b1;
         default: bus.mem_busywait = 1'b0;
      endcase
   end

   // Refill sequencer: latch block, wait out the latency, assemble four lanes.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state      <= IDLE;
         blk_q      <= '0;
         beat_cnt   <= '0;
         lat_cnt    <= '0;
         readinst_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.mem_read) begin
                  blk_q    <= bus.mem_address;
                  beat_cnt <= '0;
                  if (ACCESS_LATENCY == 0) begin
                     state <= BEAT;
                  end else begin
                     lat_cnt <= LAT_START;
                     state   <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (lat_cnt == '0) begin
                  state <= BEAT;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            BEAT: begin
               readinst_q[32*beat_cnt +: 32] <= beat_word;
               beat_cnt                      <= beat_cnt + 2'd1;
               if (beat_cnt == 2'd3) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Word array write port for program preload.
   always_ff @(posedge clock) begin
      // NOTE: the array has no reset; program contents survive a controller reset.
      if (load_ok) begin
         word_array[bus.load_addr] <= bus.load_data;
      end
   end

endmodule

// File: tb/tb_instruction_memory_controller.sv
// Directed bench for instruction_memory_controller. Instance A uses the
// default access latency; instance B uses zero latency for back-to-back refills.
module tb_instruction_memory_controller;

   logic clock;
   logic reset_a;
   logic reset_b;

   int n_checks = 0;
   int n_fail   = 0;

   instruction_memory_controller_if #(.LOAD_AW(8)) bus_a ();
   instruction_memory_controller_if #(.LOAD_AW(8)) bus_b ();

   instruction_memory_controller #(
      .DEPTH_WORDS(256), .ACCESS_LATENCY(4), .NOP_WORD(32'h00000013)
   ) dut_a (
      .clock(clock), .reset(reset_a), .bus(bus_a.slave)
   );

   instruction_memory_controller #(
      .DEPTH_WORDS(256), .ACCESS_LATENCY(0), .NOP_WORD(32'h00000013)
   ) dut_b (
      .clock(clock), .reset(reset_b), .bus(bus_b.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [127:0] BLK0 = 128'h00001003_00001002_00001001_00001000;
   localparam logic [127:0] BLK1 = 128'h00001007_00001006_00001005_00001004;
   localparam logic [127:0] NOPS = {4{32'h00000013}};

   // All tasks enter and leave at a falling edge; inputs change there.
   task automatic preload_a(input logic [7:0] addr, input logic [31:0] data);
      bus_a.load_en   = 1'b1;
      bus_a.load_addr = addr;
      bus_a.load_data = data;
      @(negedge clock);
      bus_a.load_en   = 1'b0;
   endtask

   task automatic preload_b(input logic [7:0] addr, input logic [31:0] data);
      bus_b.load_en   = 1'b1;
      bus_b.load_addr = addr;
      bus_b.load_data = data;
      @(negedge clock);
      bus_b.load_en   = 1'b0;
   endtask

   // Returns the cycle index (request cycle = 0) in which busywait first reads
   // low, or -1 on timeout, plus the block visible in that cycle.
   task automatic refill_a(input logic [27:0] addr, input bit drop,
                           input int load_cycle, input logic [7:0] laddr,
                           input logic [31:0] ldata,
                           output int busy_n, output logic [127:0] data);
      busy_n = -1;
      data   = '0;
      bus_a.mem_read    = 1'b1;
      bus_a.mem_address = addr;
      for (int n = 0; n < 40; n++) begin
         if (drop && n == 1) bus_a.mem_read = 1'b0;
         bus_a.load_en = (n == load_cycle);
         if (n == load_cycle) begin
            bus_a.load_addr = laddr;
            bus_a.load_data = ldata;
         end
         #1;
         if (!bus_a.mem_busywait) begin
            busy_n = n;
            data   = bus_a.mem_readinst;
            break;
         end
         @(negedge clock);
      end
      bus_a.mem_read = 1'b0;
      bus_a.load_en  = 1'b0;
      @(negedge clock);
   endtask

   task automatic refill_b(input logic [27:0] addr,
                           output int busy_n, output logic [127:0] data);
      busy_n = -1;
      data   = '0;
      bus_b.mem_read    = 1'b1;
      bus_b.mem_address = addr;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (!bus_b.mem_busywait) begin
            busy_n = n;
            data   = bus_b.mem_readinst;
            break;
         end
         @(negedge clock);
      end
      bus_b.mem_read = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_a = 1'b1;
      reset_b = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      n_checks++;
      if (bus_a.mem_busywait !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy_a: got %b expected 0", bus_a.mem_busywait);
      end
      n_checks++;
      if (bus_a.mem_readinst !== 128'd0) begin
         n_fail++; $display("FAIL reset_data_a: got %h expected 0", bus_a.mem_readinst);
      end
      n_checks++;
      if (bus_b.mem_busywait !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy_b: got %b expected 0", bus_b.mem_busywait);
      end
      n_checks++;
      if (bus_b.mem_readinst !== 128'd0) begin
         n_fail++; $display("FAIL reset_data_b: got %h expected 0", bus_b.mem_readinst);
      end
      reset_a = 1'b0;
      reset_b = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_basic_refill();
      int busy_n;
      logic [127:0] data;
      for (int i = 0; i < 8; i++) preload_a(8'(i), 32'h1000 + 32'(i));
      refill_a(28'd0, 1'b0, -1, 8'd0, 32'd0, busy_n, data);
      n_checks++;
      if (busy_n !== 9) begin
         n_fail++; $display("FAIL basic_latency: got %0d expected 9", busy_n);
      end
      n_checks++;
      if (data !== BLK0) begin
         n_fail++; $display("FAIL basic_data: got %h expected %h", data, BLK0);
      end
   endtask

   task automatic test_out_of_range();
      int busy_n;
      logic [127:0] data;
      refill_a(28'd64, 1'b0, -1, 8'd0, 32'd0, busy_n, data);
      n_checks++;
      if (busy_n !== 9) begin
         n_fail++; $display("FAIL oor_latency: got %0d expected 9", busy_n);
      end
      n_checks++;
      if (data !== NOPS) begin
         n_fail++; $display("FAIL oor_data: got %h expected %h", data, NOPS);
      end
   endtask

   task automatic test_reset_mid_beat();
      int busy_n;
      logic [127:0] data;
      logic [127:0] exp_partial;
      exp_partial = {32'h00000013, 32'h00000013, 32'h00001001, 32'h00001000};
      bus_a.mem_read    = 1'b1;
      bus_a.mem_address = 28'd0;
      repeat (7) @(negedge clock);
      #1;
      n_checks++;
      if (bus_a.mem_readinst !== exp_partial || bus_a.mem_busywait !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_beat_lanes: got %h busy %b expected %h busy 1",
                  bus_a.mem_readinst, bus_a.mem_busywait, exp_partial);
      end
      reset_a        = 1'b1;
      bus_a.mem_read = 1'b0;
      @(negedge clock);
      #1;
      n_checks++;
      if (bus_a.mem_busywait !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", bus_a.mem_busywait);
      end
      n_checks++;
      if (bus_a.mem_readinst !== 128'd0) begin
         n_fail++; $display("FAIL mid_reset_data: got %h expected 0", bus_a.mem_readinst);
      end
      reset_a = 1'b0;
      @(negedge clock);
      refill_a(28'd0, 1'b0, -1, 8'd0, 32'd0, busy_n, data);
      n_checks++;
      if (busy_n !== 9) begin
         n_fail++; $display("FAIL post_reset_latency: got %0d expected 9", busy_n);
      end
      n_checks++;
      if (data !== BLK0) begin
         n_fail++; $display("FAIL post_reset_data: got %h expected %h", data, BLK0);
      end
   endtask

   task automatic test_preload_gating();
      int busy_n;
      logic [127:0] data;
      logic [127:0] exp_blk;
      // Load attempted while in ACCESS must be ignored.
      refill_a(28'd0, 1'b0, 2, 8'd2, 32'hDEADBEEF, busy_n, data);
      refill_a(28'd0, 1'b0, -1, 8'd0, 32'd0, busy_n, data);
      n_checks++;
      if (data[95:64] !== 32'h00001002) begin
         n_fail++; $display("FAIL load_in_access: got %h expected 00001002", data[95:64]);
      end
      // Load together with a request in IDLE loses to the request.
      refill_a(28'd0, 1'b0, 0, 8'd3, 32'hCAFEF00D, busy_n, data);
      refill_a(28'd0, 1'b0, -1, 8'd0, 32'd0, busy_n, data);
      n_checks++;
      if (data[127:96] !== 32'h00001003) begin
         n_fail++; $display("FAIL load_with_read: got %h expected 00001003", data[127:96]);
      end
      // Load while truly idle takes effect.
      preload_a(8'd2, 32'hDEADBEEF);
      refill_a(28'd0, 1'b0, -1, 8'd0, 32'd0, busy_n, data);
      exp_blk = {32'h00001003, 32'hDEADBEEF, 32'h00001001, 32'h00001000};
      n_checks++;
      if (data !== exp_blk) begin
         n_fail++; $display("FAIL load_idle: got %h expected %h", data, exp_blk);
      end
   endtask

   task automatic test_drop_request();
      int busy_n;
      logic [127:0] data;
      logic [127:0] exp_blk;
      bit stayed_idle;
      exp_blk = {32'h00001003, 32'hDEADBEEF, 32'h00001001, 32'h00001000};
      refill_a(28'd1, 1'b1, -1, 8'd0, 32'd0, busy_n, data);
      n_checks++;
      if (busy_n !== 9) begin
         n_fail++; $display("FAIL drop_latency: got %0d expected 9", busy_n);
      end
      n_checks++;
      if (data !== BLK1 && data !== exp_blk) begin
         n_fail++; $display("FAIL drop_data: got %h expected %h", data, BLK1);
      end
      stayed_idle = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #1;
         if (bus_a.mem_busywait !== 1'b0 || bus_a.mem_readinst !== BLK1) stayed_idle = 1'b0;
         @(negedge clock);
      end
      n_checks++;
      if (!stayed_idle) begin
         n_fail++;
         $display("FAIL drop_idle: got busy %b data %h expected busy 0 data %h",
                  bus_a.mem_busywait, bus_a.mem_readinst, BLK1);
      end
   endtask

   task automatic test_back_to_back();
      int busy_n;
      logic [127:0] data;
      for (int i = 0; i < 8; i++) preload_b(8'(i), 32'h1000 + 32'(i));
      refill_b(28'd1, busy_n, data);
      n_checks++;
      if (busy_n !== 5) begin
         n_fail++; $display("FAIL b2b_first_latency: got %0d expected 5", busy_n);
      end
      n_checks++;
      if (data !== BLK1) begin
         n_fail++; $display("FAIL b2b_first_data: got %h expected %h", data, BLK1);
      end
      refill_b(28'd0, busy_n, data);
      n_checks++;
      if (busy_n !== 5) begin
         n_fail++; $display("FAIL b2b_second_latency: got %0d expected 5", busy_n);
      end
      n_checks++;
      if (data !== BLK0) begin
         n_fail++; $display("FAIL b2b_second_data: got %h expected %h", data, BLK0);
      end
   endtask

   initial begin
      reset_a = 1'b1;
      reset_b = 1'b1;
      bus_a.mem_read = 1'b0; bus_a.mem_address = '0;
      bus_a.load_en  = 1'b0; bus_a.load_addr   = '0; bus_a.load_data = '0;
      bus_b.mem_read = 1'b0; bus_b.mem_address = '0;
      bus_b.load_en  = 1'b0; bus_b.load_addr   = '0; bus_b.load_data = '0;
      @(negedge clock);
      test_reset();
      test_basic_refill();
      test_out_of_range();
      test_reset_mid_beat();
      test_preload_gating();
      test_drop_request();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
